// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, keeps one instruction-memory request in flight and drives the IF/ID register.
// Stall and Flush come from the hazard unit and the ID stage.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PCWrite,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_Instr,
  output logic        ID_Valid
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d, buf_instr_q, buf_instr_d;
  logic [31:0] id_pc_q, id_pc_d, id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  assign imem_req  = (state_q == S_REQ) && PCWrite && !Flush && !rst_i;
  assign imem_addr = pc_q;
  assign ID_PC     = id_pc_q;
  assign ID_Instr  = id_instr_q;
  assign ID_Valid  = id_valid_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = Stall ? id_instr_q : NOP_INSTR;
    id_valid_d  = Stall ? id_valid_q : 1'b0;
    if (Flush) begin
      pc_d       = BranchTarget & ~32'd3;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      // a response still owed by the memory must be swallowed before issuing again
      state_d    = ((state_q == S_WAIT || state_q == S_KILL) && !imem_valid) ? S_KILL : S_REQ;
    end else begin
      case (state_q)
        S_REQ: if (imem_req && imem_gnt) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = S_WAIT;
        end
        S_WAIT: if (imem_valid) begin
          if (Stall) begin
            buf_pc_d    = fetch_pc_q;
            buf_instr_d = imem_data;
            state_d     = S_HOLD;
          end else begin
            id_pc_d    = fetch_pc_q;
            id_instr_d = imem_data;
            id_valid_d = 1'b1;
            state_d    = S_REQ;
          end
        end
        S_HOLD: if (!Stall) begin
          id_pc_d    = buf_pc_q;
          id_instr_d = buf_instr_q;
          id_valid_d = 1'b1;
          state_d    = S_REQ;
        end
        default: if (imem_valid) state_d = S_REQ;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      id_pc_q     <= '0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus a randomized run against a stream-level fetch model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk_i = 1'b0, rst_i = 1'b1, PCWrite = 1'b1, Stall = 1'b0, Flush = 1'b0;
  logic        imem_gnt = 1'b1, imem_valid = 1'b0;
  logic [31:0] BranchTarget = '0, imem_data = '0;
  logic        imem_req, ID_Valid;
  logic [31:0] imem_addr, ID_PC, ID_Instr;
  int          n_checks = 0, n_fail = 0, mem_lat = 1;
  bit          mem_rand = 0, scramble = 0, late = 0;

  instruction_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .PCWrite(PCWrite), .Stall(Stall), .Flush(Flush),
    .BranchTarget(BranchTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_valid(imem_valid), .imem_data(imem_data),
    .ID_PC(ID_PC), .ID_Instr(ID_Instr), .ID_Valid(ID_Valid)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return scramble ? ({a[15:0], a[31:16]} ^ 32'h5A5A_5A5A) : a;
  endfunction

  // memory model: one outstanding request, response mem_lat cycles after the grant, dropped by reset
  initial begin
    logic g, r;
    logic [31:0] ga, pa;
    int cnt;
    cnt = 0;
    pa = '0;
    forever begin
      @(negedge clk_i);
      g = imem_req && imem_gnt;
      ga = imem_addr;
      r = rst_i;
      @(posedge clk_i);
      #1;
      imem_valid = 1'b0;
      if (r) cnt = 0;
      else if (g) begin
        pa = ga;
        cnt = mem_rand ? int'($urandom_range(3, 1)) : mem_lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_data = mem_word(pa);
        end
      end
      if (late) begin
        imem_valid = 1'b1;
        imem_data = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset(input logic gnt);
    rst_i = 1'b1; Flush = 1'b0; Stall = 1'b0; PCWrite = 1'b1; imem_gnt = gnt;
    late = 0; mem_lat = 1; mem_rand = 0; scramble = 0; BranchTarget = '0;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) tick();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (ID_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ID_Valid); end
    n_checks++; if (ID_Instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", ID_Instr, NOP); end
    n_checks++; if (ID_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", ID_PC); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_fetch();
    logic ev;
    do_reset(1'b1);
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_first_req: got %b/%h want 1/0", imem_req, imem_addr); end
    for (int c = 1; c <= 6; c++) begin
      tick(); #1;
      ev = (c % 2 == 0);
      n_checks++; if (ID_Valid !== ev) begin n_fail++; $display("FAIL fetch_valid c%0d: got %b want %b", c, ID_Valid, ev); end
      if (ev) begin
        n_checks++; if (ID_PC !== 32'(2 * (c - 2)) || ID_Instr !== 32'(2 * (c - 2))) begin n_fail++; $display("FAIL fetch_id c%0d: got %h/%h want %h", c, ID_PC, ID_Instr, 32'(2 * (c - 2))); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(2 * c)) begin n_fail++; $display("FAIL fetch_addr c%0d: got %b/%h want 1/%h", c, imem_req, imem_addr, 32'(2 * c)); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1);
    repeat (5) tick();
    Stall = 1'b1; PCWrite = 1'b0;
    for (int c = 6; c <= 7; c++) begin
      tick(); #1;
      n_checks++; if (ID_Valid !== 1'b0 || ID_PC !== 32'h4 || ID_Instr !== NOP) begin n_fail++; $display("FAIL stall_hold c%0d: got %b/%h/%h want 0/4/%h", c, ID_Valid, ID_PC, ID_Instr, NOP); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req c%0d: got %b want 0", c, imem_req); end
    end
    tick();
    Stall = 1'b0; PCWrite = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || ID_Valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got req %b valid %b want 0/0", imem_req, ID_Valid); end
    tick(); #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h8 || ID_Instr !== 32'h8) begin n_fail++; $display("FAIL stall_buffered: got %b/%h/%h want 1/8/8", ID_Valid, ID_PC, ID_Instr); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_resume: got %b/%h want 1/c", imem_req, imem_addr); end
    repeat (2) tick(); #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'hC) begin n_fail++; $display("FAIL stall_next: got %b/%h want 1/c", ID_Valid, ID_PC); end
  endtask

  task automatic test_flush();
    do_reset(1'b1);
    repeat (8) tick();
    Stall = 1'b1; mem_lat = 3;
    tick(); #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'hC) begin n_fail++; $display("FAIL flush_pre: got %b/%h want 1/c", ID_Valid, ID_PC); end
    Flush = 1'b1; BranchTarget = 32'h103;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %b want 0", imem_req); end
    tick();
    Flush = 1'b0; Stall = 1'b0; mem_lat = 1;
    #1;
    n_checks++; if (ID_Valid !== 1'b0 || ID_Instr !== NOP || ID_PC !== 32'hC) begin n_fail++; $display("FAIL flush_bubble: got %b/%h/%h want 0/%h/c", ID_Valid, ID_Instr, ID_PC, NOP); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_kill_req: got %b want 0", imem_req); end
    tick(); #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_stale_req: got %b want 0", imem_req); end
    tick(); #1;
    n_checks++; if (ID_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got %b want 0", ID_Valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL flush_target: got %b/%h want 1/100", imem_req, imem_addr); end
    repeat (2) tick(); #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h100 || ID_Instr !== 32'h100) begin n_fail++; $display("FAIL flush_follow: got %b/%h/%h want 1/100/100", ID_Valid, ID_PC, ID_Instr); end
  endtask

  task automatic test_flush_valid();
    do_reset(1'b1);
    tick();
    Stall = 1'b1; Flush = 1'b1; BranchTarget = 32'h40;
    tick();
    Flush = 1'b0; Stall = 1'b0;
    #1;
    n_checks++; if (ID_Valid !== 1'b0 || ID_Instr !== NOP || ID_PC !== 32'h0) begin n_fail++; $display("FAIL fv_bubble: got %b/%h/%h want 0/%h/0", ID_Valid, ID_Instr, ID_PC, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL fv_target: got %b/%h want 1/40", imem_req, imem_addr); end
    tick(); #1;
    n_checks++; if (ID_Valid !== 1'b0) begin n_fail++; $display("FAIL fv_discard: got %b want 0", ID_Valid); end
    tick(); #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h40 || ID_Instr !== 32'h40) begin n_fail++; $display("FAIL fv_follow: got %b/%h/%h want 1/40/40", ID_Valid, ID_PC, ID_Instr); end
  endtask

  task automatic test_gnt();
    do_reset(1'b0);
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      if (c == 4) imem_gnt = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL gnt_wait c%0d: got %b/%h want 1/0", c, imem_req, imem_addr); end
    end
    repeat (2) tick(); #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h0) begin n_fail++; $display("FAIL gnt_deliver: got %b/%h want 1/0", ID_Valid, ID_PC); end
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL gnt_pc_once: got %h want 4", imem_addr); end
  endtask

  task automatic test_wrap_reset();
    do_reset(1'b1);
    Flush = 1'b1; BranchTarget = 32'hFFFF_FFFF;
    tick();
    Flush = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", imem_req, imem_addr); end
    repeat (2) tick();
    mem_lat = 3;
    #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'hFFFF_FFFC || ID_Instr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_id: got %b/%h/%h want 1/fffffffc", ID_Valid, ID_PC, ID_Instr); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    tick();
    rst_i = 1'b1;
    tick();
    late = 1; imem_gnt = 1'b0; mem_lat = 1;
    #1;
    n_checks++; if (ID_PC !== 32'h0 || ID_Instr !== NOP || ID_Valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid: got pc %h instr %h v %b req %b addr %h", ID_PC, ID_Instr, ID_Valid, imem_req, imem_addr); end
    tick();
    rst_i = 1'b0; late = 0;
    tick(); #1;
    n_checks++; if (ID_Valid !== 1'b0 || ID_Instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_late: got v %b instr %h req %b addr %h", ID_Valid, ID_Instr, imem_req, imem_addr); end
    imem_gnt = 1'b1;
    repeat (2) tick(); #1;
    n_checks++; if (ID_Valid !== 1'b1 || ID_PC !== 32'h0 || ID_Instr !== 32'h0) begin n_fail++; $display("FAIL rst_restart: got %b/%h/%h want 1/0/0", ID_Valid, ID_PC, ID_Instr); end
  endtask

  // reference: decode sees consecutive words starting at the last redirect, none lost or duplicated
  task automatic test_random();
    logic ps, pf, pv;
    logic [31:0] pbt, ppc, pinstr, exp_pc;
    int deliveries;
    do_reset(1'b1);
    scramble = 1; mem_rand = 1;
    exp_pc = 32'h0;
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      Stall = ($urandom_range(3) == 0);
      PCWrite = ($urandom_range(4) != 0);
      imem_gnt = ($urandom_range(3) != 0);
      Flush = ($urandom_range(19) == 0);
      BranchTarget = $urandom;
      ps = Stall; pf = Flush; pbt = BranchTarget;
      ppc = ID_PC; pinstr = ID_Instr; pv = ID_Valid;
      tick(); #1;
      if (pf) begin
        n_checks++; if (ID_Valid !== 1'b0 || ID_Instr !== NOP || ID_PC !== ppc) begin n_fail++; $display("FAIL rnd_flush %0d: got %b/%h/%h want 0/%h/%h", i, ID_Valid, ID_Instr, ID_PC, NOP, ppc); end
        exp_pc = pbt & ~32'd3;
      end else if (ps) begin
        n_checks++; if (ID_Valid !== pv || ID_Instr !== pinstr || ID_PC !== ppc) begin n_fail++; $display("FAIL rnd_stall %0d: got %b/%h/%h want %b/%h/%h", i, ID_Valid, ID_Instr, ID_PC, pv, pinstr, ppc); end
      end else if (ID_Valid === 1'b1) begin
        n_checks++; if (ID_PC !== exp_pc || ID_Instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_deliver %0d: got %h/%h want %h/%h", i, ID_PC, ID_Instr, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        n_checks++; if (ID_Instr !== NOP || ID_PC !== ppc) begin n_fail++; $display("FAIL rnd_bubble %0d: got %h/%h want %h/%h", i, ID_Instr, ID_PC, NOP, ppc); end
      end
    end
    Stall = 1'b0; Flush = 1'b0;
    n_checks++; if (deliveries < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >= 100", deliveries); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_flush_valid();
    test_gnt();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
